// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator call scheduler slice.
// Latency: n/a (constants, types and pure functions only).
// Backpressure: n/a.
//
// Contents: floor count, one-hot floor constants, scheduler state encoding,
// one-hot validity check and one-hot to index conversion.
package elevator_pkg;

  localparam int NUM_FLOORS = 4;
  localparam int FLOOR_W    = $clog2(NUM_FLOORS);

  localparam logic [NUM_FLOORS-1:0] FLOOR_0 = 4'b0001;
  localparam logic [NUM_FLOORS-1:0] FLOOR_1 = 4'b0010;
  localparam logic [NUM_FLOORS-1:0] FLOOR_2 = 4'b0100;
  localparam logic [NUM_FLOORS-1:0] FLOOR_3 = 4'b1000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MOVING = 2'd1,
    DWELL  = 2'd2
  } sched_state_t;

  function automatic logic is_one_hot(input logic [NUM_FLOORS-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

  // Only meaningful for one-hot inputs; callers gate on is_one_hot().
  function automatic logic [FLOOR_W-1:0] floor_index(input logic [NUM_FLOORS-1:0] v);
    logic [FLOOR_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (v[i]) idx = FLOOR_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/call_debouncer.sv
// Synchronises one raw call button, debounces it and emits a one-cycle press pulse.
// Latency: press pulse visible 2 + DEBOUNCE_CYCLES cycles after the first high sample.
// Backpressure: none; the button is sampled every cycle and pulses are never held.
//
// Ports:
//   clk    in   system clock
//   reset  in   synchronous active-high reset
//   btn    in   raw asynchronous button level
//   press  out  single-cycle pulse on the rising edge of the debounced level
module call_debouncer #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic          stable_q;
  logic [CW-1:0] cnt;
  logic          stable;

  // Counter saturates at DEBOUNCE_CYCLES, so the level stays accepted while
  // the button is held and the pulse fires only once per press.
  assign stable = (cnt == CW'(DEBOUNCE_CYCLES));
  assign press  = stable & ~stable_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      cnt      <= '0;
      stable_q <= 1'b0;
    end else begin
      sync1    <= btn;
      sync2    <= sync1;
      stable_q <= stable;
      if (!sync2) begin
        cnt <= '0;
      end else if (!stable) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/elevator_call_scheduler.sv
// Latches debounced call buttons and picks a SCAN target floor for the car controller.
// Latency: press-to-pending 2 + DEBOUNCE_CYCLES + 1 cycles; target/door outputs registered (1 cycle).
// Backpressure: none; the controller is expected to follow requested_floor, inputs sampled every cycle.
//
// Ports:
//   clk              in   system clock
//   reset            in   synchronous active-high reset
//   tick             in   one-cycle pulse per second, counted only while dwelling
//   call_btn         in   raw call buttons, one per floor
//   present_floor    in   one-hot current car floor
//   requested_floor  out  one-hot target floor (FLOOR_0 when present_floor is invalid)
//   pending_calls    out  latched unserviced calls
//   door_open        out  high while dwelling at a serviced floor
//   dir_up           out  current sweep direction, 1 = up
module elevator_call_scheduler
  import elevator_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int DWELL_TICKS     = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tick,
  input  logic [NUM_FLOORS-1:0] call_btn,
  input  logic [NUM_FLOORS-1:0] present_floor,
  output logic [NUM_FLOORS-1:0] requested_floor,
  output logic [NUM_FLOORS-1:0] pending_calls,
  output logic                  door_open,
  output logic                  dir_up
);

  localparam int DW = $clog2(DWELL_TICKS + 1);

  sched_state_t          state;
  logic [DW-1:0]         dwell_cnt;
  logic [NUM_FLOORS-1:0] target_q;
  logic [NUM_FLOORS-1:0] press;
  logic [NUM_FLOORS-1:0] sel_floor;
  logic [NUM_FLOORS-1:0] set_mask;
  logic [NUM_FLOORS-1:0] clr_mask;
  logic [NUM_FLOORS-1:0] pending_next;
  logic [FLOOR_W-1:0]    cur_idx;
  logic [FLOOR_W-1:0]    tgt_idx;
  logic [FLOOR_W-1:0]    sel_idx;
  logic [FLOOR_W-1:0]    above_idx;
  logic [FLOOR_W-1:0]    below_idx;
  logic                  above_vld;
  logic                  below_vld;
  logic                  sel_vld;
  logic                  sel_flip;
  logic                  pf_valid;
  logic                  enter_dwell;
  logic                  absorb;
  logic                  retarget;

  for (genvar f = 0; f < NUM_FLOORS; f++) begin : g_deb
    call_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk  (clk),
      .reset(reset),
      .btn  (call_btn[f]),
      .press(press[f])
    );
  end

  assign pf_valid = is_one_hot(present_floor);
  assign cur_idx  = floor_index(present_floor);
  assign tgt_idx  = floor_index(target_q);

  // Nearest pending floor above (lowest index > car) and below (highest index < car).
  always_comb begin
    above_vld = 1'b0;
    above_idx = '0;
    below_vld = 1'b0;
    below_idx = '0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (pending_calls[i] && (i > int'(cur_idx))) begin
        above_vld = 1'b1;
        above_idx = FLOOR_W'(i);
      end
    end
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pending_calls[i] && (i < int'(cur_idx))) begin
        below_vld = 1'b1;
        below_idx = FLOOR_W'(i);
      end
    end
  end

  // SCAN: keep sweeping while there is work ahead, otherwise reverse.
  always_comb begin
    sel_vld  = 1'b0;
    sel_flip = 1'b0;
    sel_idx  = '0;
    if (dir_up) begin
      if (above_vld) begin
        sel_vld = 1'b1;
        sel_idx = above_idx;
      end else if (below_vld) begin
        sel_vld  = 1'b1;
        sel_flip = 1'b1;
        sel_idx  = below_idx;
      end
    end else begin
      if (below_vld) begin
        sel_vld = 1'b1;
        sel_idx = below_idx;
      end else if (above_vld) begin
        sel_vld  = 1'b1;
        sel_flip = 1'b1;
        sel_idx  = above_idx;
      end
    end
  end

  assign sel_floor = FLOOR_0 << sel_idx;

  assign enter_dwell = pf_valid &&
                       (((state == IDLE) && (|(pending_calls & present_floor))) ||
                        ((state == MOVING) && (present_floor == target_q)));

  // A press for the floor the door is already open at is swallowed and
  // extends the dwell instead of becoming a pending call.
  assign absorb = pf_valid && (state == DWELL) && (|(press & present_floor));

  // Only a same-direction call closer than the current target can steal it.
  assign retarget = (state == MOVING) && sel_vld && !sel_flip &&
                    (dir_up ? (sel_idx < tgt_idx) : (sel_idx > tgt_idx));

  // Clear beats a simultaneous press on the same bit.
  assign set_mask     = (pf_valid && (state == DWELL)) ? (press & ~present_floor) : press;
  assign clr_mask     = enter_dwell ? present_floor : '0;
  assign pending_next = (pending_calls | set_mask) & ~clr_mask;

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      pending_calls   <= '0;
      requested_floor <= FLOOR_0;
      target_q        <= FLOOR_0;
      door_open       <= 1'b0;
      dir_up          <= 1'b1;
      dwell_cnt       <= '0;
    end else begin
      pending_calls <= pending_next;
      if (!pf_valid) begin
        // Unknown car position: freeze the FSM and park the request at floor 0.
        requested_floor <= FLOOR_0;
      end else if (enter_dwell) begin
        state           <= DWELL;
        door_open       <= 1'b1;
        dwell_cnt       <= '0;
        requested_floor <= present_floor;
      end else begin
        case (state)
          IDLE: begin
            if (sel_vld) begin
              state           <= MOVING;
              target_q        <= sel_floor;
              requested_floor <= sel_floor;
              if (sel_flip) dir_up <= ~dir_up;
            end else begin
              requested_floor <= present_floor;
            end
          end
          MOVING: begin
            if (retarget) begin
              target_q        <= sel_floor;
              requested_floor <= sel_floor;
            end else begin
              requested_floor <= target_q;
            end
          end
          DWELL: begin
            requested_floor <= present_floor;
            if (absorb) begin
              dwell_cnt <= '0;
            end else if (tick) begin
              dwell_cnt <= dwell_cnt + DW'(1);
              if (dwell_cnt == DW'(DWELL_TICKS - 1)) begin
                state     <= IDLE;
                door_open <= 1'b0;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Scoreboard bench for elevator_call_scheduler: directed scenarios then random traffic.
// Latency: expectations are queued per clock edge and compared 1 time unit after it.
// Backpressure: n/a.
module tb_elevator_call_scheduler;
  import elevator_pkg::*;

  localparam int DEB = 4;
  localparam int DT  = 2;
  localparam int M_IDLE   = 0;
  localparam int M_MOVING = 1;
  localparam int M_DWELL  = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic [3:0] call_btn;
  logic [3:0] present_floor;
  logic [3:0] requested_floor;
  logic [3:0] pending_calls;
  logic       door_open;
  logic       dir_up;

  always #5 clk = ~clk;

  elevator_call_scheduler #(
    .DEBOUNCE_CYCLES(DEB),
    .DWELL_TICKS    (DT)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .tick           (tick),
    .call_btn       (call_btn),
    .present_floor  (present_floor),
    .requested_floor(requested_floor),
    .pending_calls  (pending_calls),
    .door_open      (door_open),
    .dir_up         (dir_up)
  );

  typedef struct packed {
    logic [3:0] req;
    logic [3:0] pend;
    logic       door;
    logic       dir;
  } obs_t;

  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state (abstract: floor numbers, run lengths, a delay line).
  int         m_mode;
  logic [3:0] m_pend, m_req, m_tgt;
  logic       m_door, m_dir;
  int         m_cnt;
  int         run[4];
  logic [3:0] ev[3];
  logic [3:0] pf;

  task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int idx_of(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [3:0] bit_of(input int f);
    logic [3:0] v;
    v = '0;
    v[f] = 1'b1;
    return v;
  endfunction

  function automatic int nearest(input logic [3:0] v, input int cur, input logic up);
    for (int d = 1; d < 4; d++) begin
      int f;
      f = up ? cur + d : cur - d;
      if (f >= 0 && f < 4) begin
        if (v[f]) return f;
      end
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_pend = '0; m_req = 4'b0001; m_tgt = 4'b0001;
    m_door = 1'b0; m_dir = 1'b1; m_cnt = 0;
    for (int f = 0; f < 4; f++) run[f] = 0;
    for (int k = 0; k < 3; k++) ev[k] = '0;
  endtask

  // State after the coming clock edge, given the inputs applied before it.
  task automatic model_step(input logic [3:0] btn, input logic tk, input logic rst, input logic [3:0] p);
    logic [3:0] matured, newev, old, setm, clr;
    int cur, tg, best;
    if (rst) begin
      model_reset();
      return;
    end
    // A button high for DEB consecutive samples becomes a call 3 edges later.
    matured = ev[0];
    ev[0] = ev[1];
    ev[1] = ev[2];
    newev = '0;
    for (int f = 0; f < 4; f++) begin
      run[f] = btn[f] ? run[f] + 1 : 0;
      if (run[f] == DEB) newev[f] = 1'b1;
    end
    ev[2] = newev;
    old  = m_pend;
    setm = matured;
    clr  = '0;
    if ($countones(p) != 1) begin
      m_pend = old | setm;
      m_req  = 4'b0001;
      return;
    end
    cur = idx_of(p);
    if ((m_mode == M_IDLE && old[cur]) || (m_mode == M_MOVING && p == m_tgt)) begin
      m_mode = M_DWELL; m_door = 1'b1; m_cnt = 0; m_req = p; clr = p;
    end else if (m_mode == M_IDLE) begin
      if (old != 0) begin
        best = nearest(old, cur, m_dir);
        if (best < 0) begin
          m_dir = !m_dir;
          best = nearest(old, cur, m_dir);
        end
        m_tgt = bit_of(best); m_req = m_tgt; m_mode = M_MOVING;
      end else begin
        m_req = p;
      end
    end else if (m_mode == M_MOVING) begin
      tg = idx_of(m_tgt);
      best = -1;
      if (m_dir) begin
        for (int f = tg - 1; f > cur; f--) if (old[f]) best = f;
      end else begin
        for (int f = tg + 1; f < cur; f++) if (old[f]) best = f;
      end
      if (best >= 0) m_tgt = bit_of(best);
      m_req = m_tgt;
    end else begin
      m_req = p;
      setm = matured & ~p;
      if (matured[cur]) begin
        m_cnt = 0;
      end else if (tk) begin
        m_cnt++;
        if (m_cnt == DT) begin
          m_mode = M_IDLE; m_door = 1'b0;
        end
      end
    end
    m_pend = (old | setm) & ~clr;
  endtask

  task automatic cyc(input logic [3:0] btn, input logic tk, input logic rst);
    obs_t e;
    @(negedge clk);
    call_btn = btn; tick = tk; reset = rst; present_floor = pf;
    model_step(btn, tk, rst, pf);
    e.req = m_req; e.pend = m_pend; e.door = m_door; e.dir = m_dir;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(4'b0000, 1'b0, 1'b0);
  endtask

  task automatic press(input int f, input int n);
    repeat (n) cyc(bit_of(f), 1'b0, 1'b0);
  endtask

  task automatic do_tick();
    cyc(4'b0000, 1'b1, 1'b0);
  endtask

  task automatic peek();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every edge the DUT presents a new registered output set.
  initial begin : monitor
    obs_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_requested_floor", requested_floor, e.req);
        chk("sb_pending_calls", pending_calls, e.pend);
        chk("sb_door_open", {3'b000, door_open}, {3'b000, e.door});
        chk("sb_dir_up", {3'b000, dir_up}, {3'b000, e.dir});
      end
    end
  end

  initial begin : stim
    logic [3:0] rbtn;
    int car, cd;
    reset = 1'b1; tick = 1'b0; call_btn = '0; present_floor = FLOOR_0;
    pf = FLOOR_0;
    model_reset();

    // Reset values
    repeat (3) cyc(4'b0000, 1'b0, 1'b1);
    peek();
    chk("rst_req", requested_floor, FLOOR_0);
    chk("rst_pend", pending_calls, 4'b0000);
    chk("rst_door", {3'b000, door_open}, 4'b0000);
    chk("rst_dir", {3'b000, dir_up}, 4'b0001);

    // Glitch shorter than the debounce window
    press(2, 3);
    idle(12);
    peek();
    chk("glitch_pend", pending_calls, 4'b0000);

    // Valid press: pending exactly 7 edges after the first high sample
    press(2, 6);
    peek();
    chk("lat_pend_edge6", pending_calls, 4'b0000);
    press(2, 1);
    peek();
    chk("lat_pend_edge7", pending_calls, FLOOR_2);
    press(2, 1);
    peek();
    chk("lat_req_edge8", requested_floor, FLOOR_2);
    idle(1);
    pf = FLOOR_1; idle(2);
    pf = FLOOR_2; idle(2);
    peek();
    chk("arrive2_door", {3'b000, door_open}, 4'b0001);
    chk("arrive2_pend", pending_calls, 4'b0000);
    do_tick(); idle(1); do_tick(); idle(2);
    peek();
    chk("dwell2_close", {3'b000, door_open}, 4'b0000);

    // Retarget to a nearer call in the sweep direction
    repeat (2) cyc(4'b0000, 1'b0, 1'b1);
    pf = FLOOR_0; idle(1);
    press(3, 6); idle(3);
    peek();
    chk("move_req3", requested_floor, FLOOR_3);
    press(1, 6); idle(3);
    peek();
    chk("retarget_req1", requested_floor, FLOOR_1);
    pf = FLOOR_1; idle(2);
    peek();
    chk("arrive1_door", {3'b000, door_open}, 4'b0001);
    chk("arrive1_pend", pending_calls, FLOOR_3);
    do_tick(); idle(1); do_tick(); idle(3);
    peek();
    chk("resume_req3", requested_floor, FLOOR_3);

    // Top floor reversal and invalid present_floor
    pf = FLOOR_2; idle(2);
    pf = FLOOR_3; idle(2);
    do_tick(); idle(1); do_tick(); idle(2);
    peek();
    chk("top_dir_up", {3'b000, dir_up}, 4'b0001);
    chk("top_req", requested_floor, FLOOR_3);
    pf = 4'b0110; idle(2);
    peek();
    chk("bad_pf_req", requested_floor, FLOOR_0);
    chk("bad_pf_pend", pending_calls, 4'b0000);
    pf = FLOOR_3; idle(1);
    press(0, 6); idle(3);
    peek();
    chk("rev_dir", {3'b000, dir_up}, 4'b0000);
    chk("rev_req", requested_floor, FLOOR_0);

    // Dwell extension by a press at the open floor
    press(2, 6); idle(3);
    peek();
    chk("down_retarget", requested_floor, FLOOR_2);
    pf = FLOOR_2; idle(2);
    do_tick(); idle(1);
    press(2, 6); idle(2);
    peek();
    chk("absorb_pend", pending_calls, FLOOR_0);
    chk("absorb_door", {3'b000, door_open}, 4'b0001);
    do_tick(); idle(1);
    peek();
    chk("ext_door_open", {3'b000, door_open}, 4'b0001);
    do_tick(); idle(1);
    peek();
    chk("ext_door_closed", {3'b000, door_open}, 4'b0000);

    // Reset during dwell drops pending calls
    pf = FLOOR_0; idle(2);
    press(3, 6); idle(1);
    peek();
    chk("pre_rst_door", {3'b000, door_open}, 4'b0001);
    do_tick();
    cyc(4'b0000, 1'b0, 1'b1);
    peek();
    chk("dwell_rst_req", requested_floor, FLOOR_0);
    chk("dwell_rst_pend", pending_calls, 4'b0000);
    chk("dwell_rst_door", {3'b000, door_open}, 4'b0000);
    chk("dwell_rst_dir", {3'b000, dir_up}, 4'b0001);

    // Random traffic; the car follows the model's requested floor
    rbtn = '0; car = 0; cd = 3;
    for (int c = 0; c < 3000; c++) begin
      int t;
      logic rst, tk;
      for (int f = 0; f < 4; f++) if ($urandom_range(0, 11) == 0) rbtn[f] = ~rbtn[f];
      rst = ($urandom_range(0, 699) == 0);
      tk  = ($urandom_range(0, 5) == 0);
      if (cd == 0) begin
        t = idx_of(m_req);
        if (t > car) car++;
        else if (t >= 0 && t < car) car--;
        cd = $urandom_range(2, 5);
      end else begin
        cd--;
      end
      if ($urandom_range(0, 149) == 0) pf = ($urandom_range(0, 1) == 1) ? 4'b0000 : 4'b0110;
      else pf = bit_of(car);
      cyc(rbtn, tk, rst);
    end
    idle(3);
    @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
